// File: rtl/lsu_stage.sv
// Load/store unit stage: decodes RV32 loads/stores, runs a single
// outstanding req/gnt/rvalid memory transaction and aligns load data.
module lsu_stage #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic [31:0]           instr_i,
    input  logic [31:0]           alu_result_i,
    input  logic [31:0]           store_data_i,
    output logic                  stall_o,
    output logic                  valid_o,
    output logic [31:0]           instr_o,
    output logic [31:0]           alu_result_o,
    output logic [31:0]           load_data_o,
    output logic                  err_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [3:0]            mem_be_o,
    output logic [31:0]           mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [31:0]           mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

    state_t r_state;
    state_t w_next;

    logic [31:0] r_p_instr;
    logic [31:0] r_p_alu;
    logic        r_p_we;
    logic [3:0]  r_p_be;
    logic [31:0] r_p_wdata;

    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_alu;
    logic [31:0] r_data;
    logic        r_err;

    logic [2:0]  w_f3;
    logic        w_is_ld;
    logic        w_is_st;
    logic        w_f3_ok;
    logic        w_mis;
    logic        w_err;
    logic        w_go;
    logic [3:0]  w_be;
    logic [31:0] w_wd;
    logic [31:0] w_sh;
    logic [31:0] w_ld_data;
    logic        w_req;
    logic        w_stall;
    logic        w_latch;
    logic        w_done;
    logic [31:0] w_o_instr;
    logic [31:0] w_o_alu;
    logic [31:0] w_o_data;
    logic        w_o_err;

    assign w_f3    = instr_i[14:12];
    assign w_is_ld = (instr_i[6:0] == 7'b0000011);
    assign w_is_st = (instr_i[6:0] == 7'b0100011);
    assign w_f3_ok = w_is_ld ? (w_f3 != 3'd3 && w_f3 != 3'd6 && w_f3 != 3'd7)
                             : (w_f3 <= 3'd2);
    assign w_mis   = ((w_f3[1:0] == 2'b01) && alu_result_i[0])
                  || ((w_f3[1:0] == 2'b10) && (alu_result_i[1:0] != 2'b00));
    assign w_err   = (w_is_ld || w_is_st) && (!w_f3_ok || w_mis);
    assign w_go    = (w_is_ld || w_is_st) && !w_err;

    // Byte enables and replicated write data for the incoming access
    always_comb begin
        w_be = 4'b1111;
        w_wd = store_data_i;
        if (w_is_st) begin
            unique case (1'b1)
                (w_f3[1:0] == 2'b00): begin
                    w_be = 4'b0001 << alu_result_i[1:0];
                    w_wd = {4{store_data_i[7:0]}};
                end
                (w_f3[1:0] == 2'b01): begin
                    w_be = 4'b0011 << {alu_result_i[1], 1'b0};
                    w_wd = {2{store_data_i[15:0]}};
                end
                default: begin
                    w_be = 4'b1111;
                    w_wd = store_data_i;
                end
            endcase
        end
    end

    // Halves are always halfword-aligned, so one shifter serves all sizes
    assign w_sh = mem_rdata_i >> {r_p_alu[1:0], 3'b000};

    // Extract and extend load data from the latched funct3
    always_comb begin
        w_ld_data = '0;
        unique case (r_p_instr[14:12])
            3'd0:    w_ld_data = {{24{w_sh[7]}}, w_sh[7:0]};
            3'd1:    w_ld_data = {{16{w_sh[15]}}, w_sh[15:0]};
            3'd2:    w_ld_data = w_sh;
            3'd4:    w_ld_data = {24'd0, w_sh[7:0]};
            3'd5:    w_ld_data = {16'd0, w_sh[15:0]};
            default: w_ld_data = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state, stall and completion selection
    always_comb begin
        w_next    = r_state;
        w_stall   = 1'b0;
        w_latch   = 1'b0;
        w_done    = 1'b0;
        w_o_instr = r_p_instr;
        w_o_alu   = r_p_alu;
        w_o_data  = '0;
        w_o_err   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (valid_i) begin
                    if (w_go) begin
                        w_latch = 1'b1;
                        w_stall = 1'b1;
                        w_next  = REQ;
                    end else begin
                        w_done    = 1'b1;
                        w_o_instr = instr_i;
                        w_o_alu   = alu_result_i;
                        w_o_err   = w_err;
                    end
                end
            end
            REQ: begin
                w_stall = 1'b1;
                if (mem_gnt_i) begin
                    if (r_p_we) begin
                        w_stall = 1'b0;
                        w_done  = 1'b1;
                        w_next  = IDLE;
                    end else begin
                        w_next = WAIT_R;
                    end
                end
            end
            WAIT_R: begin
                w_stall = 1'b1;
                if (mem_rvalid_i) begin
                    w_stall  = 1'b0;
                    w_done   = 1'b1;
                    w_o_data = w_ld_data;
                    w_next   = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Capture the accepted load/store so upstream may change afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_instr <= '0;
            r_p_alu   <= '0;
            r_p_we    <= 1'b0;
            r_p_be    <= '0;
            r_p_wdata <= '0;
        end else if (w_latch) begin
            r_p_instr <= instr_i;
            r_p_alu   <= alu_result_i;
            r_p_we    <= w_is_st;
            r_p_be    <= w_be;
            r_p_wdata <= w_wd;
        end
    end

    // Output registers: load on completion, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_alu   <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= w_done;
            if (w_done) begin
                r_instr <= w_o_instr;
                r_alu   <= w_o_alu;
                r_data  <= w_o_data;
                r_err   <= w_o_err;
            end
        end
    end

    assign w_req        = (r_state == REQ);
    assign stall_o      = w_stall & rst_n;
    assign valid_o      = r_valid;
    assign instr_o      = r_instr;
    assign alu_result_o = r_alu;
    assign load_data_o  = r_data;
    assign err_o        = r_err;
    assign mem_req_o    = w_req;
    assign mem_we_o     = w_req & r_p_we;
    assign mem_addr_o   = w_req ? {r_p_alu[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign mem_be_o     = w_req ? r_p_be : '0;
    assign mem_wdata_o  = w_req ? r_p_wdata : '0;

endmodule

// File: doc/lsu_stage.md
LSU_STAGE -- requirements
Module: lsu_stage

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, SHALL set the number of byte-address bits presented to data memory.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all state updates on the rising edge.
  rst_n  in  1  asynchronous, active-low reset.
  valid_i  in  1  instr_i/alu_result_i/store_data_i valid.
  instr_i  in  32  instruction from execute.
  alu_result_i  in  32  ALU result; effective byte address for loads/stores.
  store_data_i  in  32  rs2 value for stores.
  stall_o  out  1  hold upstream inputs stable.
  valid_o  out  1  output registers hold a newly completed instruction.
  instr_o  out  32  registered instruction.
  alu_result_o  out  32  registered ALU result.
  load_data_o  out  32  aligned, extended load data (0 for non-loads).
  err_o  out  1  misaligned or unsupported funct3 load/store.
  mem_req_o  out  1  memory request.
  mem_we_o  out  1  1 = write.
  mem_addr_o  out  ADDR_WIDTH  word-aligned byte address.
  mem_be_o  out  4  byte enables.
  mem_wdata_o  out  32  write data.
  mem_gnt_i  in  1  request accepted this cycle.
  mem_rvalid_i  in  1  mem_rdata_i valid.
  mem_rdata_i  in  32  read data.

Function
REQ-003 Decode SHALL be: opcode instr[6:0] 0000011 = load, 0100011 = store; funct3 instr[14:12]; loads LB 0, LH 1, LW 2, LBU 4, LHU 5; stores SB 0, SH 1, SW 2.
REQ-004 Errors: load/store with another funct3, halfword access with addr[0]=1, or word access with addr[1:0]!=0 SHALL issue no memory request and SHALL complete in 1 cycle with err_o=1, load_data_o=0.
REQ-005 The FSM SHALL have states IDLE, REQ, WAIT_R; reset state IDLE.
REQ-006 IDLE with valid_i=1, valid load/store: latch instr, address, store data; go to REQ; stall_o=1 this cycle.
REQ-007 IDLE with valid_i=1, non-memory or error instruction: output registers load next edge, valid_o=1 for 1 cycle, stall_o=0.
REQ-008 IDLE with valid_i=0: valid_o=0 next cycle; instr_o, alu_result_o, load_data_o, err_o hold.
REQ-009 mem_req_o SHALL equal (state==REQ); mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o SHALL be stable while mem_req_o=1.
REQ-010 REQ with mem_gnt_i=1: a store SHALL complete (outputs load, valid_o=1 next cycle, go IDLE); a load SHALL go to WAIT_R.
REQ-011 WAIT_R with mem_rvalid_i=1: extract load data, load outputs, valid_o=1 next cycle, go IDLE; mem_rvalid_i outside WAIT_R SHALL be ignored.
REQ-012 stall_o SHALL be 1 in REQ and WAIT_R except in the completing cycle (gnt for store, rvalid for load), where it SHALL be 0; latched values, not instr_i, SHALL be used after IDLE.
REQ-013 mem_addr_o SHALL be {addr[ADDR_WIDTH-1:2], 2'b00}.
REQ-014 Loads: mem_we_o=0, mem_be_o=4'b1111.
REQ-015 SB: be = 4'b0001 << addr[1:0], wdata = byte replicated 4x; SH: be = 4'b0011 << {addr[1],1'b0}, wdata = halfword replicated 2x; SW: be=4'b1111, wdata=store_data.
REQ-016 Load data: byte = rdata[8*addr[1:0] +: 8], half = rdata[16*addr[1] +: 16]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-017 At most one memory transaction SHALL be outstanding.

Reset
REQ-018 rst_n=0 SHALL immediately force state IDLE and every output to 0, aborting any in-flight transaction; a late mem_gnt_i/mem_rvalid_i after reset SHALL be ignored.

Verification
REQ-019 SW addr 0x104, data 0xDEADBEEF, gnt in first REQ cycle -> addr 0x104, be 1111, wdata 0xDEADBEEF, stall_o high 1 cycle, valid_o next cycle.
REQ-020 LB addr 0x103, rdata 0x80FF1234 -> load_data_o 0xFFFFFF80; LBU same -> 0x00000080.
REQ-021 SH addr 0x00A, data 0x0000ABCD -> be 1100, wdata 0xABCDABCD.
REQ-022 LW addr 0x102 -> err_o=1, mem_req_o never 1, stall_o=0, valid_o next cycle.
REQ-023 LH addr 0x002, gnt after 3 REQ cycles, rvalid 2 cycles later with 0x80010000 -> request fields stable, stall_o held, load_data_o 0xFFFF8001.
REQ-024 rst_n low in WAIT_R -> all outputs 0 at once; after release an ADD completes in 1 cycle with valid_o=1.
